// File: rtl/sclib_tmr_scrub_ctrl.sv
// sclib_tmr_scrub_ctrl: periodic majority-vote scrubber for a TMR register bank; SCLIB_TMR_SCRUB_UNCORR_EN adds uncorrectable-word counting.
module sclib_tmr_scrub_ctrl #(
    parameter int NREG = 8,
    parameter int DW = 32,
    parameter int INTERVAL = 1024,
    parameter int ECW = 16,
    localparam int IW = $clog2(NREG)
) (
    input  logic          CLK,
    input  logic          SRB,
    input  logic          ENABLE,
    input  logic          START,
    output logic [IW-1:0] RD_IDX,
    input  logic [DW-1:0] RD_D0,
    input  logic [DW-1:0] RD_D1,
    input  logic [DW-1:0] RD_D2,
    output logic          WR_EN,
    output logic [IW-1:0] WR_IDX,
    output logic [DW-1:0] WR_DATA,
    output logic [2:0]    WR_MASK,
    input  logic          HOST_WE,
    input  logic [IW-1:0] HOST_IDX,
    output logic          BUSY,
    output logic [ECW-1:0] ERR_CNT,
    input  logic          ERR_CLR,
    output logic          ERR_IRQ,
`ifdef SCLIB_TMR_SCRUB_UNCORR_EN
    output logic [ECW-1:0] UNCORR_CNT,
    output logic          UNCORR_IRQ,
`endif
    output logic [IW-1:0] LAST_ERR_IDX
);
    localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    typedef enum logic [2:0] {IDLE, WAIT, RD, CHK, WB} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, wr_idx_q, wr_idx_d, last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic wr_en_q, wr_en_d, irq_q, irq_d;
    logic [DW-1:0] wr_data_q, wr_data_d, maj;
    logic [2:0] wr_mask_q, wr_mask_d, mis;
    logic [ECW-1:0] err_cnt_q, err_cnt_d;
    logic host_hit, err_det, adv;
    assign maj = (RD_D0 & RD_D1) | (RD_D0 & RD_D2) | (RD_D1 & RD_D2);
    assign mis = {RD_D2 != maj, RD_D1 != maj, RD_D0 != maj};
    assign host_hit = HOST_WE && (HOST_IDX == idx_q);
    assign err_det = (state_q == CHK) && (mis != 3'b000) && !host_hit;
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        cnt_d = cnt_q;
        adv = 1'b0;
        wr_en_d = 1'b0;
        wr_idx_d = wr_idx_q;
        wr_data_d = wr_data_q;
        wr_mask_d = wr_mask_q;
        case (state_q)
            IDLE: if (START || ENABLE) begin
                state_d = RD;
                idx_d = '0;
            end
            WAIT: if (START || (ENABLE && cnt_q == '0)) begin
                state_d = RD;
                idx_d = '0;
            end else if (!ENABLE) state_d = IDLE;
            else cnt_d = cnt_q - 1'b1;
            RD: state_d = CHK;
            CHK: if (err_det) begin
                state_d = WB;
                wr_en_d = 1'b1;
                wr_idx_d = idx_q;
                wr_data_d = maj;
                wr_mask_d = mis;
            end else adv = 1'b1;
            WB: adv = 1'b1;
            default: state_d = IDLE;
        endcase
        if (adv) begin
            if (idx_q == IW'(NREG - 1)) begin
                state_d = ENABLE ? WAIT : IDLE;
                idx_d = '0;
                cnt_d = CW'(INTERVAL - 1);
            end else begin
                state_d = RD;
                idx_d = idx_q + 1'b1;
            end
        end
    end
    // clear wins over saturation; a simultaneous new error restarts the count at one
    assign err_cnt_d = ERR_CLR ? ECW'(err_det) : (err_det && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
    assign last_d = err_det ? idx_q : last_q;
    assign irq_d = err_det;
    always_ff @(posedge CLK) begin
        if (!SRB) begin
            state_q <= IDLE;
            idx_q <= '0;
            cnt_q <= '0;
            wr_en_q <= 1'b0;
            wr_idx_q <= '0;
            wr_data_q <= '0;
            wr_mask_q <= '0;
            err_cnt_q <= '0;
            last_q <= '0;
            irq_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            wr_en_q <= wr_en_d;
            wr_idx_q <= wr_idx_d;
            wr_data_q <= wr_data_d;
            wr_mask_q <= wr_mask_d;
            err_cnt_q <= err_cnt_d;
            last_q <= last_d;
            irq_q <= irq_d;
        end
    end
`ifdef SCLIB_TMR_SCRUB_UNCORR_EN
    logic [ECW-1:0] unc_cnt_q, unc_cnt_d;
    logic unc_irq_q, unc_det;
    assign unc_det = err_det && (RD_D0 != RD_D1) && (RD_D1 != RD_D2) && (RD_D0 != RD_D2);
    assign unc_cnt_d = ERR_CLR ? ECW'(unc_det) : (unc_det && !(&unc_cnt_q)) ? unc_cnt_q + 1'b1 : unc_cnt_q;
    always_ff @(posedge CLK) begin
        if (!SRB) begin
            unc_cnt_q <= '0;
            unc_irq_q <= 1'b0;
        end else begin
            unc_cnt_q <= unc_cnt_d;
            unc_irq_q <= unc_det;
        end
    end
    assign UNCORR_CNT = unc_cnt_q;
    assign UNCORR_IRQ = unc_irq_q;
`endif
    assign RD_IDX = idx_q;
    // the host owns the bank: a same-index host write suppresses the scrub write
    assign WR_EN = wr_en_q && !host_hit;
    assign WR_IDX = wr_idx_q;
    assign WR_DATA = wr_data_q;
    assign WR_MASK = wr_mask_q;
    assign BUSY = (state_q == RD) || (state_q == CHK) || (state_q == WB);
    assign ERR_CNT = err_cnt_q;
    assign ERR_IRQ = irq_q;
    assign LAST_ERR_IDX = last_q;
endmodule

// File: tb/tb_sclib_tmr_scrub_ctrl.sv
// tb_sclib_tmr_scrub_ctrl: scoreboard bench for sclib_tmr_scrub_ctrl (NREG=8, INTERVAL=4, ECW=2).
module tb_sclib_tmr_scrub_ctrl;
    localparam int NREG = 8;
    localparam int DW = 32;
    localparam int INTERVAL = 4;
    localparam int ECW = 2;
    localparam int IW = 3;
    logic CLK = 1'b0, SRB = 1'b0, ENABLE = 1'b0, START = 1'b0, HOST_WE = 1'b0, ERR_CLR = 1'b0;
    logic [IW-1:0] HOST_IDX = '0;
    logic [IW-1:0] RD_IDX, WR_IDX, LAST_ERR_IDX;
    logic [DW-1:0] RD_D0, RD_D1, RD_D2, WR_DATA;
    logic [2:0] WR_MASK;
    logic WR_EN, BUSY, ERR_IRQ;
    logic [ECW-1:0] ERR_CNT;
`ifdef SCLIB_TMR_SCRUB_UNCORR_EN
    logic [ECW-1:0] UNCORR_CNT;
    logic UNCORR_IRQ;
    logic [ECW-1:0] uq[$];
`endif
    sclib_tmr_scrub_ctrl #(.NREG(NREG), .DW(DW), .INTERVAL(INTERVAL), .ECW(ECW)) dut (
        .CLK(CLK), .SRB(SRB), .ENABLE(ENABLE), .START(START),
        .RD_IDX(RD_IDX), .RD_D0(RD_D0), .RD_D1(RD_D1), .RD_D2(RD_D2),
        .WR_EN(WR_EN), .WR_IDX(WR_IDX), .WR_DATA(WR_DATA), .WR_MASK(WR_MASK),
        .HOST_WE(HOST_WE), .HOST_IDX(HOST_IDX), .BUSY(BUSY), .ERR_CNT(ERR_CNT),
        .ERR_CLR(ERR_CLR), .ERR_IRQ(ERR_IRQ),
`ifdef SCLIB_TMR_SCRUB_UNCORR_EN
        .UNCORR_CNT(UNCORR_CNT), .UNCORR_IRQ(UNCORR_IRQ),
`endif
        .LAST_ERR_IDX(LAST_ERR_IDX)
    );
    always #5 CLK = ~CLK;
    logic [DW-1:0] mem [NREG][3];
    // bank model: registered read, data valid the cycle after RD_IDX changes
    always @(posedge CLK) begin
        RD_D0 <= mem[RD_IDX][0];
        RD_D1 <= mem[RD_IDX][1];
        RD_D2 <= mem[RD_IDX][2];
    end
    typedef struct {logic [IW-1:0] idx; logic [DW-1:0] data; logic [2:0] mask;} wr_t;
    typedef struct {string nm; int sel; logic [31:0] exp;} probe_t;
    wr_t wq[$];
    probe_t pq[$];
    logic [IW-1:0] iq[$];
    int lq[$], gq[$];
    int n_cmp = 0, n_bad = 0, busy_run = 0, idle_run = 0;
    logic done = 1'b0;
    probe_t p;
    wr_t w;
    function automatic logic [DW-1:0] base(int i);
        return DW'(i) * 32'h1111_1111;
    endfunction
    function automatic logic [31:0] act(int sel);
        case (sel)
            0: return 32'(BUSY);
            1: return 32'(ERR_CNT);
            2: return 32'(LAST_ERR_IDX);
            3: return 32'(WR_EN);
            4: return 32'(RD_IDX);
            5: return 32'(WR_IDX);
            6: return WR_DATA;
            7: return 32'(WR_MASK);
            8: return 32'(ERR_IRQ);
`ifdef SCLIB_TMR_SCRUB_UNCORR_EN
            9: return 32'(UNCORR_CNT);
`endif
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction
    task automatic cmp(string nm, logic [31:0] a, logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, a, e);
        end
    endtask
    task automatic tick(int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask
    task automatic probe(string nm, int sel, logic [31:0] e);
        pq.push_back('{nm, sel, e});
    endtask
    task automatic pulse_start();
        START = 1'b1;
        tick(1);
        START = 1'b0;
    endtask
    always @(negedge CLK) begin
        while (pq.size() > 0) begin
            p = pq.pop_front();
            cmp(p.nm, act(p.sel), p.exp);
        end
        if (WR_EN === 1'b1) begin
            cmp("wr_expected", 32'(wq.size() > 0), 1);
            if (wq.size() > 0) begin
                w = wq.pop_front();
                cmp("wr_idx", 32'(WR_IDX), 32'(w.idx));
                cmp("wr_data", WR_DATA, w.data);
                cmp("wr_mask", 32'(WR_MASK), 32'(w.mask));
            end
        end
        if (ERR_IRQ === 1'b1) begin
            cmp("irq_expected", 32'(iq.size() > 0), 1);
            if (iq.size() > 0) cmp("last_err_idx", 32'(LAST_ERR_IDX), 32'(iq.pop_front()));
        end
`ifdef SCLIB_TMR_SCRUB_UNCORR_EN
        if (UNCORR_IRQ === 1'b1) begin
            cmp("uncorr_irq_expected", 32'(uq.size() > 0), 1);
            if (uq.size() > 0) cmp("uncorr_cnt", 32'(UNCORR_CNT), 32'(uq.pop_front()));
        end
`endif
        if (BUSY === 1'b1) begin
            if (idle_run > 0 && gq.size() > 0) cmp("pass_gap", 32'(idle_run), 32'(gq.pop_front()));
            idle_run = 0;
            busy_run++;
        end else begin
            if (busy_run > 0) begin
                cmp("pass_expected", 32'(lq.size() > 0), 1);
                if (lq.size() > 0) cmp("pass_len", 32'(busy_run), 32'(lq.pop_front()));
            end
            busy_run = 0;
            idle_run++;
        end
        if (done) begin
            cmp("writes_left", 32'(wq.size()), 0);
            cmp("irqs_left", 32'(iq.size()), 0);
            cmp("passes_left", 32'(lq.size()), 0);
            cmp("gaps_left", 32'(gq.size()), 0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end
    initial begin
        for (int i = 0; i < NREG; i++) for (int r = 0; r < 3; r++) mem[i][r] = base(i);
        tick(2);
        probe("rst_busy", 0, 0);
        probe("rst_err_cnt", 1, 0);
        probe("rst_last_idx", 2, 0);
        probe("rst_wr_en", 3, 0);
        probe("rst_rd_idx", 4, 0);
        probe("rst_wr_idx", 5, 0);
        probe("rst_wr_data", 6, 0);
        probe("rst_wr_mask", 7, 0);
        probe("rst_err_irq", 8, 0);
        tick(1);
        SRB = 1'b1;
        tick(2);
        // clean pass
        lq.push_back(16);
        pulse_start();
        tick(20);
        probe("clean_err_cnt", 1, 0);
        // single-bit error on replica 1 of register 3
        for (int r = 0; r < 3; r++) mem[3][r] = '0;
        mem[3][1] = 32'h0000_0001;
        wq.push_back('{3'd3, 32'h0, 3'b010});
        iq.push_back(3'd3);
        lq.push_back(17);
        pulse_start();
        tick(22);
        probe("fix_err_cnt", 1, 1);
        probe("fix_last_idx", 2, 3);
        for (int r = 0; r < 3; r++) mem[3][r] = base(3);
        // host write to the corrupted register wins, nothing counted
        mem[5][2] = ~base(5);
        HOST_WE = 1'b1;
        HOST_IDX = 3'd5;
        lq.push_back(16);
        pulse_start();
        tick(20);
        HOST_WE = 1'b0;
        probe("host_err_cnt", 1, 1);
        mem[5][2] = base(5);
        // five errors saturate a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            mem[i][0] = base(i) ^ 32'h80;
            wq.push_back('{IW'(i), base(i), 3'b001});
            iq.push_back(IW'(i));
        end
        lq.push_back(21);
        pulse_start();
        tick(26);
        probe("sat_err_cnt", 1, 3);
        for (int i = 0; i < 5; i++) mem[i][0] = base(i);
        // clear coincident with an error on register 2 (CHK of idx 2)
        mem[2][1] = ~base(2);
        wq.push_back('{3'd2, base(2), 3'b010});
        iq.push_back(3'd2);
        lq.push_back(17);
        pulse_start();
        tick(5);
        ERR_CLR = 1'b1;
        tick(1);
        ERR_CLR = 1'b0;
        probe("clr_inc_err_cnt", 1, 1);
        tick(16);
        mem[2][1] = base(2);
        // automatic passes separated by INTERVAL idle cycles, then disable mid-pass
        ENABLE = 1'b1;
        repeat (3) lq.push_back(16);
        tick(2);
        gq.push_back(INTERVAL);
        gq.push_back(INTERVAL);
        tick(43);
        ENABLE = 1'b0;
        tick(25);
        probe("idle_after_disable", 0, 0);
        // reset while the write-back is on the bus
        mem[0][0] = ~base(0);
        wq.push_back('{3'd0, base(0), 3'b001});
        iq.push_back(3'd0);
        lq.push_back(3);
        pulse_start();
        tick(2);
        SRB = 1'b0;
        tick(1);
        probe("rst_wb_wr_en", 3, 0);
        probe("rst_wb_busy", 0, 0);
        probe("rst_wb_err_cnt", 1, 0);
        SRB = 1'b1;
        tick(10);
        probe("no_reissue_busy", 0, 0);
        mem[0][0] = base(0);
`ifdef SCLIB_TMR_SCRUB_UNCORR_EN
        mem[6][0] = 32'h1;
        mem[6][1] = 32'h2;
        mem[6][2] = 32'h4;
        wq.push_back('{3'd6, 32'h0, 3'b111});
        iq.push_back(3'd6);
        uq.push_back(1);
        lq.push_back(17);
        pulse_start();
        tick(22);
        probe("unc_cnt", 9, 1);
        probe("unc_err_cnt", 1, 1);
        for (int r = 0; r < 3; r++) mem[6][r] = base(6);
`endif
        tick(2);
        done = 1'b1;
        tick(5);
    end
endmodule

// File: doc/sclib_tmr_scrub_ctrl.md
SCLIB_TMR_SCRUB_CTRL -- requirements
Module: sclib_tmr_scrub_ctrl

Interface
REQ-001 The block SHALL have parameter NREG, default 8: number of TMR registers in the scrubbed bank (2..256).
REQ-002 The block SHALL have parameter DW, default 32: width of each replica word.
REQ-003 The block SHALL have parameter INTERVAL, default 1024: idle cycles between automatic scrub passes (>=1).
REQ-004 The block SHALL have parameter ECW, default 16: error counter width.
REQ-005 The block SHALL have port CLK, input, 1: single clock; all logic on its rising edge.
REQ-006 The block SHALL have port SRB, input, 1: reset, synchronous, active-low.
REQ-007 The block SHALL have ports ENABLE (in, 1, automatic scrubbing enable) and START (in, 1, one-cycle request for an immediate pass).
REQ-008 The block SHALL have ports RD_IDX (out, IW=clog2(NREG), register index being read) and RD_D0/RD_D1/RD_D2 (in, DW each, replica values at RD_IDX, valid the cycle after RD_IDX changes).
REQ-009 The block SHALL have ports WR_EN (out, 1), WR_IDX (out, IW), WR_DATA (out, DW, voted word) and WR_MASK (out, 3, replicas to rewrite, bit n = replica n).
REQ-010 The block SHALL have ports HOST_WE (in, 1) and HOST_IDX (in, IW): host write to the bank, which has priority over scrub writes.
REQ-011 The block SHALL have ports BUSY (out, 1), ERR_CNT (out, ECW), ERR_CLR (in, 1), ERR_IRQ (out, 1, one-cycle pulse) and LAST_ERR_IDX (out, IW).

Function
REQ-012 The FSM SHALL have states IDLE, WAIT, RD, CHK and WB.
REQ-013 In IDLE, START=1 or ENABLE=1 SHALL go to RD with idx=0; START has precedence and needs no ENABLE.
REQ-014 In WAIT, a down-counter loaded with INTERVAL-1 SHALL decrement each cycle; at 0 it SHALL go to RD with idx=0; START SHALL go to RD immediately; ENABLE=0 SHALL go to IDLE.
REQ-015 In RD, RD_IDX=idx SHALL be driven, with the next state CHK; RD_IDX SHALL hold idx in CHK and WB.
REQ-016 In CHK, RD_D0..2 SHALL be sampled and a per-bit majority computed; per-replica mismatch m[n] = (RD_Dn != majority).
REQ-017 In CHK, if m!=0 and not (HOST_WE=1 and HOST_IDX==idx), the next state SHALL be WB; otherwise the block SHALL advance.
REQ-018 In WB, WR_EN=1, WR_IDX=idx, WR_DATA=majority and WR_MASK=m SHALL be driven for exactly one cycle; if HOST_WE=1 and HOST_IDX==idx in that cycle, WR_EN SHALL be 0 (host wins) and the error SHALL still be counted.
REQ-019 On each detected mismatch in CHK, ERR_CNT SHALL increment and saturate at all-ones, LAST_ERR_IDX SHALL load idx, and ERR_IRQ SHALL pulse the following cycle; a host-conflict skip SHALL not count.
REQ-020 Advance SHALL be: if idx==NREG-1, go to WAIT (ENABLE=1) or IDLE (ENABLE=0); else idx+1, go to RD.
REQ-021 START during a pass SHALL be ignored.
REQ-022 A clean pass SHALL take 2*NREG cycles; each corrected register SHALL add 1 cycle.
REQ-023 BUSY SHALL be 1 in RD, CHK and WB.
REQ-024 ERR_CLR SHALL zero ERR_CNT; ERR_CLR coincident with an increment SHALL give ERR_CNT=1.
REQ-025 ENABLE deasserted mid-pass SHALL let the pass complete, then go to IDLE.

Reset
REQ-026 On SRB=0 at a clock edge, the block SHALL enter IDLE with idx=0 and the wait counter=0, and set WR_EN=0, WR_IDX=0, WR_DATA=0, WR_MASK=0, RD_IDX=0, BUSY=0, ERR_CNT=0, ERR_IRQ=0 and LAST_ERR_IDX=0.
REQ-027 Reset mid-WB SHALL deassert WR_EN at the same edge; the interrupted write SHALL not be reissued.

Configuration
REQ-028 The block SHALL support the macro SCLIB_TMR_SCRUB_UNCORR_EN.
REQ-029 With SCLIB_TMR_SCRUB_UNCORR_EN defined, the block SHALL add outputs UNCORR_CNT (ECW, saturating, cleared by ERR_CLR) and UNCORR_IRQ (pulse); a word where all three replicas differ pairwise SHALL count as uncorrectable, pulse UNCORR_IRQ, still write back the majority and still count in ERR_CNT.
REQ-030 Without SCLIB_TMR_SCRUB_UNCORR_EN, those ports and the logic SHALL be absent, and all mismatches SHALL be treated as correctable.

Verification
REQ-031 The bench SHALL cover: NREG=8, all replicas equal, START pulse -> BUSY high for 16 cycles, WR_EN never asserted, ERR_CNT=0.
REQ-032 The bench SHALL cover: idx 3 with RD_D1=0x0000_0001 and others 0 -> one WB with WR_IDX=3, WR_DATA=0, WR_MASK=3'b010, ERR_CNT=1, LAST_ERR_IDX=3, ERR_IRQ pulse, and a 17-cycle pass.
REQ-033 The bench SHALL cover: mismatch at idx 5 with HOST_WE=1 and HOST_IDX=5 during CHK -> no WB, ERR_CNT unchanged.
REQ-034 The bench SHALL cover: ECW=2 with 5 errors -> ERR_CNT stays 3; ERR_CLR together with an error -> ERR_CNT=1.
REQ-035 The bench SHALL cover: ENABLE=1, INTERVAL=4 -> passes start exactly 4 cycles after each pass ends; SRB=0 in WB -> WR_EN=0 at that edge and the FSM in IDLE.
REQ-036 The bench SHALL cover, with SCLIB_TMR_SCRUB_UNCORR_EN: replicas 0x1, 0x2 and 0x4 -> WR_DATA=0, WR_MASK=3'b111, UNCORR_CNT=1 and a UNCORR_IRQ pulse.
